// File: rtl/leak_mon_pkg.sv
// rtl/leak_mon_pkg.sv - shared FSM encoding and saturating increment for leak_monitor
package leak_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Increment that sticks at the all-ones value of a width-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    return (value == max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/leak_lat_capture.sv
// rtl/leak_lat_capture.sv - first-done latency capture for one multiplier copy
module leak_lat_capture
  import leak_mon_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 done,
  output logic                 got,
  output logic [CNT_WIDTH-1:0] lat
);

  // arm covers the trial window; outside it the capture is held cleared so
  // every trial starts from got=0, lat=0. Only the first done is recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got <= 1'b0;
      lat <= '0;
    end else if (!arm) begin
      got <= 1'b0;
      lat <= '0;
    end else if (done && !got) begin
      got <= 1'b1;
      lat <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/leak_monitor.sv
// rtl/leak_monitor.sv - two-copy latency leak monitor; optional LEAK_MON_STOP_ON_LEAK_EN halts on first leak
module leak_monitor
  import leak_mon_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 64,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  done_one,
  input  logic                  done_two,
  input  logic                  clear,
  output logic                  trial_valid,
  output logic                  trial_leak,
  output logic                  trial_timeout,
  output logic [CNT_WIDTH-1:0]  lat_delta,
  output logic                  leak_sticky,
  output logic [STAT_WIDTH-1:0] trial_count,
  output logic [STAT_WIDTH-1:0] leak_count,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 timeout_q;
  logic                 arm;
  logic                 got_one, got_two;
  logic [CNT_WIDTH-1:0] lat_one, lat_two;
  logic                 both_next;
  logic                 leak;
  logic [CNT_WIDTH-1:0] delta;

  assign cnt_inc   = cnt + 1'b1;
  assign arm       = (state == RUN) || (state == REPORT);
  // Counts a done arriving on this very edge so the final capture and the
  // transition to REPORT happen together.
  assign both_next = (got_one | done_one) & (got_two | done_two);
  assign leak      = timeout_q | (lat_one != lat_two);

  leak_lat_capture #(.CNT_WIDTH(CNT_WIDTH)) u_cap_one (
    .clk  (clk),
    .rst  (rst),
    .arm  (arm),
    .cnt  (cnt),
    .done (done_one),
    .got  (got_one),
    .lat  (lat_one)
  );

  leak_lat_capture #(.CNT_WIDTH(CNT_WIDTH)) u_cap_two (
    .clk  (clk),
    .rst  (rst),
    .arm  (arm),
    .cnt  (cnt),
    .done (done_two),
    .got  (got_two),
    .lat  (lat_two)
  );

  // Absolute latency difference; ordering the operands means it cannot underflow
  always_comb begin
    delta = '0;
    if (lat_one >= lat_two) delta = lat_one - lat_two;
    else                    delta = lat_two - lat_one;
  end

  // Trial FSM with registered results and statistics; clear is applied last so it wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      timeout_q     <= 1'b0;
      busy          <= 1'b0;
      trial_valid   <= 1'b0;
      trial_leak    <= 1'b0;
      trial_timeout <= 1'b0;
      lat_delta     <= '0;
      leak_sticky   <= 1'b0;
      trial_count   <= '0;
      leak_count    <= '0;
    end else begin
      trial_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (both_next) begin
            state <= REPORT;
          end else if (cnt_inc == TIMEOUT_C) begin
            timeout_q <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          trial_valid   <= 1'b1;
          trial_leak    <= leak;
          trial_timeout <= timeout_q;
          lat_delta     <= delta;
          trial_count   <= STAT_WIDTH'(sat_inc(32'(trial_count), STAT_WIDTH));
          if (leak) begin
            leak_count  <= STAT_WIDTH'(sat_inc(32'(leak_count), STAT_WIDTH));
            leak_sticky <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
`ifdef LEAK_MON_STOP_ON_LEAK_EN
          if (leak) begin
            state <= HALT;
            busy  <= 1'b1;
          end
`endif
        end
`ifdef LEAK_MON_STOP_ON_LEAK_EN
        HALT: begin
          if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (clear) begin
        trial_leak    <= 1'b0;
        trial_timeout <= 1'b0;
        lat_delta     <= '0;
        leak_sticky   <= 1'b0;
        trial_count   <= '0;
        leak_count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_leak_monitor.sv
// tb/tb_leak_monitor.sv - scoreboard bench for leak_monitor
module tb_leak_monitor;

  localparam int CW = 8;
  localparam int TO = 16;
  localparam int SW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          done_one;
  logic          done_two;
  logic          clear;
  logic          trial_valid;
  logic          trial_leak;
  logic          trial_timeout;
  logic [CW-1:0] lat_delta;
  logic          leak_sticky;
  logic [SW-1:0] trial_count;
  logic [SW-1:0] leak_count;
  logic          busy;

  leak_monitor #(.CNT_WIDTH(CW), .TIMEOUT(TO), .STAT_WIDTH(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done_one      (done_one),
    .done_two      (done_two),
    .clear         (clear),
    .trial_valid   (trial_valid),
    .trial_leak    (trial_leak),
    .trial_timeout (trial_timeout),
    .lat_delta     (lat_delta),
    .leak_sticky   (leak_sticky),
    .trial_count   (trial_count),
    .leak_count    (leak_count),
    .busy          (busy)
  );

  typedef struct {
    int leak;
    int tmo;
    int delta;
    int tc;
    int lc;
    int st;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_tc   = 0;
  int   exp_lc   = 0;
  int   exp_st   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bitm(input int d);
    return (d == 0) ? 32'd0 : (32'd1 << d);
  endfunction

  // Monitor: pops the expected result whenever the DUT presents one
  always @(negedge clk) begin
    if (trial_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_trial_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("trial_leak", int'(trial_leak), e.leak);
        check("trial_timeout", int'(trial_timeout), e.tmo);
        check("lat_delta", int'(lat_delta), e.delta);
        check("trial_count", int'(trial_count), e.tc);
        check("leak_count", int'(leak_count), e.lc);
        check("leak_sticky", int'(leak_sticky), e.st);
      end
    end
  end

  // One trial: done/start masks are indexed by edge number after the start edge
  task automatic trial(input logic [31:0] m1, input logic [31:0] m2, input logic [31:0] ms,
                       input int end_edge, input int e_leak, input int e_tmo, input int e_delta,
                       input bit clr_in_report);
    exp_t e;
    int   s;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    if (clr_in_report) begin
      exp_tc = 0;
      exp_lc = 0;
      exp_st = 0;
      e.leak  = 0;
      e.tmo   = 0;
      e.delta = 0;
    end else begin
      exp_tc++;
      if (e_leak != 0) begin
        exp_lc++;
        exp_st = 1;
      end
      e.leak  = e_leak;
      e.tmo   = e_tmo;
      e.delta = e_delta;
    end
    e.tc  = exp_tc;
    e.lc  = exp_lc;
    e.st  = exp_st;
    e.cyc = s + end_edge + 1;
    exp_q.push_back(e);
    for (int k = 1; k <= end_edge + 3; k++) begin
      done_one = m1[k];
      done_two = m2[k];
      start    = ms[k];
      clear    = clr_in_report && (k == end_edge + 1);
      tick();
    end
    done_one = 1'b0;
    done_two = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_tc = 0;
    exp_lc = 0;
    exp_st = 0;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    done_one = 1'b0;
    done_two = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(trial_valid), 0);
    check("reset_leak", int'(trial_leak), 0);
    check("reset_timeout", int'(trial_timeout), 0);
    check("reset_delta", int'(lat_delta), 0);
    check("reset_sticky", int'(leak_sticky), 0);
    check("reset_trial_count", int'(trial_count), 0);
    check("reset_leak_count", int'(leak_count), 0);
    rst = 1'b1;
    tick();

`ifdef LEAK_MON_STOP_ON_LEAK_EN
    trial(bitm(4), bitm(7), 32'd0, 7, 1, 0, 3, 1'b0);
    check("halt_busy", int'(busy), 1);
    repeat (2) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    check("halt_trial_count", int'(trial_count), 1);
    check("halt_busy_after_starts", int'(busy), 1);
    check("halt_delta_frozen", int'(lat_delta), 3);
    pulse_clear();
    check("clear_from_halt_busy", int'(busy), 0);
    check("clear_from_halt_count", int'(trial_count), 0);
    trial(bitm(4), bitm(4), 32'd0, 4, 0, 0, 0, 1'b0);
`else
    // equal, skewed and timed-out trials
    trial(bitm(4), bitm(4), 32'd0, 4, 0, 0, 0, 1'b0);
    check("equal_busy_after", int'(busy), 0);
    trial(bitm(4), bitm(7), 32'd0, 7, 1, 0, 3, 1'b0);
    trial(bitm(5), 32'd0, 32'd0, TO, 1, 1, 5, 1'b0);
    check("hold_timeout", int'(trial_timeout), 1);
    check("hold_delta", int'(lat_delta), 5);

    // reset two edges into a trial aborts it with no result
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_trial_count", int'(trial_count), 0);
    check("midrun_reset_sticky", int'(leak_sticky), 0);
    #1 rst = 1'b1;
    exp_tc = 0;
    exp_lc = 0;
    exp_st = 0;
    done_one = 1'b1;
    done_two = 1'b1;
    repeat (2) tick();
    done_one = 1'b0;
    done_two = 1'b0;
    repeat (3) tick();
    check("idle_ignores_done_busy", int'(busy), 0);

    // start during RUN and duplicate done pulses give one trial
    trial(bitm(3) | bitm(5), bitm(3), bitm(2), 3, 0, 0, 0, 1'b0);
    repeat (3) tick();
    check("dup_busy", int'(busy), 0);
    check("dup_trial_count", int'(trial_count), 1);

    pulse_clear();
    check("clear_trial_count", int'(trial_count), 0);
    check("clear_leak_count", int'(leak_count), 0);

    // done exactly on the timeout edge is a capture, not a timeout
    trial(bitm(3), bitm(TO), 32'd0, TO, 1, 0, 13, 1'b0);
    trial(32'd0, 32'd0, 32'd0, TO, 1, 1, 0, 1'b0);
    pulse_clear();
    check("clear_sticky", int'(leak_sticky), 0);
    check("clear_result_leak", int'(trial_leak), 0);
    check("clear_result_delta", int'(lat_delta), 0);

    // three good trials, clear lands in the third REPORT cycle
    trial(bitm(1), bitm(1), 32'd0, 1, 0, 0, 0, 1'b0);
    trial(bitm(2), bitm(2), 32'd0, 2, 0, 0, 0, 1'b0);
    trial(bitm(6), bitm(6), 32'd0, 6, 0, 0, 0, 1'b1);
    check("report_clear_trial_count", int'(trial_count), 0);
    check("report_clear_sticky", int'(leak_sticky), 0);
`endif

    repeat (3) tick();
    check("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leak_monitor.md
Name: leak_monitor

Overview:
Downstream consumer of the two-copy constant-time multiplier tester. Watches the shared start pulse and both copies' productDone lines, measures each copy's latency in cycles, and flags any trial where the latencies differ or a copy never finishes. Keeps sticky and counted leak statistics across many trials for the bench or a debug register file.

Parameters:
CNT_WIDTH, 8, width of per-trial latency counters and delta output
TIMEOUT, 64, cycles after start before a missing done is declared a timeout; must be < 2**CNT_WIDTH
STAT_WIDTH, 16, width of trial and leak statistic counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  trial start, same pulse that drives both multiplier copies
done_one  input  1  productDone of copy one
done_two  input  1  productDone of copy two
clear  input  1  synchronous clear of statistics and sticky flags
trial_valid  output  1  one-cycle pulse: trial result outputs are valid
trial_leak  output  1  result of the last trial: latencies differed or timed out
trial_timeout  output  1  result of the last trial: at least one done missing at TIMEOUT
lat_delta  output  CNT_WIDTH  |lat_one - lat_two| of the last trial
leak_sticky  output  1  set by any leaking trial, held until clear
trial_count  output  STAT_WIDTH  completed trials, saturating
leak_count  output  STAT_WIDTH  leaking trials, saturating
busy  output  1  high in RUN and REPORT

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; internal cnt, lat_one, lat_two, got_one, got_two = 0.
- FSM states: IDLE, RUN, REPORT.
- IDLE: start high at an edge -> cnt=0, got_* = 0, lat_* = 0, go to RUN. Done inputs are ignored in IDLE.
- RUN: cnt increments every cycle.
  - First edge where done_x=1 and got_x=0: lat_x <= cnt+1 and got_x <= 1. Latency is the number of edges from the start edge to the done edge; a done asserted one cycle after start gives latency 1.
  - Later done_x pulses in the same trial are ignored.
  - Both got (including the same-edge capture of the final done) -> REPORT.
  - cnt+1 == TIMEOUT with a got flag still 0 -> REPORT with timeout=1; the uncaptured lat stays 0.
  - start during RUN or REPORT is ignored; no restart.
- REPORT (exactly 1 cycle):
  - trial_valid=1.
  - trial_timeout = timeout.
  - trial_leak = timeout | (lat_one != lat_two).
  - lat_delta = absolute difference, computed as an unsigned subtract in CNT_WIDTH+1 bits and truncated.
  - trial_count++ (saturating at all-ones); leak_count++ if leak (saturating); leak_sticky |= leak.
  - Next state IDLE.
  - trial_leak, trial_timeout and lat_delta hold their values until the next REPORT. trial_valid falls after this cycle.
- clear (synchronous): zeroes trial_count, leak_count, leak_sticky, trial_leak, trial_timeout, lat_delta. It does not affect the FSM. If clear coincides with REPORT, clear wins for the statistics and sticky flag; trial_valid still pulses.
- Reset mid-trial aborts immediately. No partial result is reported.
- Total latency: result visible one cycle after the later done edge.

Optional Feature:
LEAK_MON_STOP_ON_LEAK_EN
- Defined: after the first leaking REPORT the FSM enters HALT instead of IDLE. In HALT, start is ignored, busy=1 and all result outputs are frozen. clear returns HALT to IDLE and clears statistics. This preserves the first divergent trial for debug.
- Undefined: no HALT state; monitoring continues after leaks.

Decomposition:
- Shared package leak_mon_pkg: FSM state encoding (IDLE, RUN, REPORT, HALT) and a saturating-increment function used by all counters.
- One natural sub-module, leak_lat_capture, instantiated twice (one per copy). It holds got_x and lat_x, with ports clk, rst, arm, cnt, done, got, lat.

Test Plan:
- Equal latency: start, then done_one and done_two both 4 cycles later -> trial_valid 1 cycle later; trial_leak=0, lat_delta=0, trial_count=1, leak_count=0.
- Skew: done_one at +4, done_two at +7 -> trial_leak=1, lat_delta=3, leak_sticky=1, leak_count=1.
- Timeout: TIMEOUT=16, done_one at +5, done_two never -> REPORT at edge 16; trial_timeout=1, trial_leak=1, lat_delta=5.
- Start during RUN plus duplicate done pulses: second start at +2 and done_one pulsing at +3 and +5, done_two at +3 -> one trial only, lat_delta=0, trial_count=1.
- Reset mid-RUN at +2, then clear with count=3: no trial_valid, counters 0; after 3 good trials, clear in the REPORT cycle -> trial_count=0, leak_sticky=0.
- With LEAK_MON_STOP_ON_LEAK_EN: skew trial then 2 further starts -> trial_count stays 1 and busy=1 until clear; after clear, state is IDLE.
